// File: rtl/mult_seq_ctrl.sv
// Sequencer for a fixed-latency sequential multiplier: queues operand pairs,
// strobes load/start, waits out the latency and hands each product downstream.
module mult_seq_ctrl #(
    parameter int WIDTH      = 4,
    parameter int LATENCY    = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    output logic               mul_enable,
    output logic               mul_start,
    input  logic [2*WIDTH-1:0] mul_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] res_product,
    output logic               busy,
    output logic [7:0]         job_count
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [2*WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]      count_reg;
    logic               fifo_full, fifo_empty;
    logic               push, pop;

    logic [WIDTH-1:0]   mul_a_reg, mul_b_reg;
    logic [LW-1:0]      cnt_reg;
    logic               res_valid_reg;
    logic [2*WIDTH-1:0] res_product_reg;
    logic [7:0]         job_count_reg;
    logic               capture, handoff;

    assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign in_ready   = !fifo_full;
    assign push       = in_valid && !fifo_full;

    // Storage has no reset so it maps onto plain RAM; pointers carry the state.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {in_a, in_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        mul_enable = 1'b0;
        mul_start  = 1'b0;
        capture    = 1'b0;
        handoff    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                mul_enable = 1'b1;
                state_next = ST_START;
            end
            ST_START: begin
                mul_start  = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_reg == '0) begin
                    capture    = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    handoff    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            mul_a_reg       <= '0;
            mul_b_reg       <= '0;
            cnt_reg         <= '0;
            res_valid_reg   <= 1'b0;
            res_product_reg <= '0;
            job_count_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (pop) begin
                {mul_a_reg, mul_b_reg} <= fifo_mem[rd_ptr_reg];
            end
            // Counter spans exactly LATENCY cycles of WAIT, including the capture cycle.
            if (state_reg == ST_START) begin
                cnt_reg <= LW'(LATENCY - 1);
            end else if (state_reg == ST_WAIT && cnt_reg != '0) begin
                cnt_reg <= cnt_reg - LW'(1);
            end
            if (capture) begin
                res_product_reg <= mul_out;
                res_valid_reg   <= 1'b1;
            end else if (handoff) begin
                res_valid_reg   <= 1'b0;
            end
            if (handoff) begin
                job_count_reg <= job_count_reg + 8'd1;
            end
        end
    end

    assign mul_a       = mul_a_reg;
    assign mul_b       = mul_b_reg;
    assign res_valid   = res_valid_reg;
    assign res_product = res_product_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign job_count   = job_count_reg;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: behavioural fixed-latency multiplier plus a
// queue-based model of accepted pairs and their expected products.
module tb_mult_seq_ctrl;
    localparam int WIDTH      = 4;
    localparam int LATENCY    = 8;
    localparam int FIFO_DEPTH = 2;
    localparam int PW         = 2 * WIDTH;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [WIDTH-1:0] mul_a, mul_b;
    logic             mul_enable, mul_start;
    logic [PW-1:0]    mul_out = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [PW-1:0]    res_product;
    logic             busy;
    logic [7:0]       job_count;

    int         pass_cnt = 0;
    int         total_cnt = 0;
    logic [7:0] exp_jobs = '0;

    always #5 clk = ~clk;

    mult_seq_ctrl #(.WIDTH(WIDTH), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .mul_a(mul_a), .mul_b(mul_b),
        .mul_enable(mul_enable), .mul_start(mul_start), .mul_out(mul_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_product(res_product),
        .busy(busy), .job_count(job_count)
    );

    // Multiplier stand-in: operands latched on enable, garbage until LATENCY cycles after start.
    logic [WIDTH-1:0] ma_lat = '0, mb_lat = '0;
    int               mcnt = 0;
    always @(posedge clk) begin
        if (mul_enable) begin
            ma_lat <= mul_a;
            mb_lat <= mul_b;
        end
        if (mul_start) begin
            if (LATENCY == 1) begin
                mul_out <= PW'(ma_lat) * PW'(mb_lat);
            end else begin
                mul_out <= (PW'(ma_lat) * PW'(mb_lat)) ^ PW'(8'hA5);
                mcnt    <= LATENCY - 1;
            end
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) mul_out <= PW'(ma_lat) * PW'(mb_lat);
        end
    end

    // Reference model and protocol monitor, sampled mid-cycle.
    int exp_q[$];
    int got_log[$];
    int exp_log[$];
    int got_cyc[$];
    int cyc = 0, enable_cyc = 0, start_cyc = 0, overlap_cnt = 0, stab_err = 0, resv_cyc = 0;
    int last_enable_cyc = -1, last_start_cyc = -1;
    logic track = 1'b0;
    logic [WIDTH-1:0] held_a = '0, held_b = '0;
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            track = 1'b0;
        end else begin
            if (in_valid && in_ready) exp_q.push_back(int'(in_a) * int'(in_b));
            if (mul_enable) begin
                enable_cyc++;
                last_enable_cyc = cyc;
                held_a = mul_a;
                held_b = mul_b;
                track  = 1'b1;
            end else if (track && (mul_a !== held_a || mul_b !== held_b)) begin
                stab_err++;
            end
            if (mul_start) begin
                start_cyc++;
                last_start_cyc = cyc;
            end
            if (mul_enable && mul_start) overlap_cnt++;
            if (res_valid) begin
                resv_cyc++;
                track = 1'b0;
            end
            if (res_valid && res_ready) begin
                got_log.push_back(int'(res_product));
                got_cyc.push_back(cyc);
                if (exp_q.size() > 0) exp_log.push_back(exp_q.pop_front());
                else exp_log.push_back(-1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int w = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            total_cnt++;
            $display("FAIL push_timeout: in_ready stayed %b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, input int bound, input string name);
        int w = 0;
        while (got_log.size() < n && w < bound) begin
            tick();
            w++;
        end
        if (got_log.size() < n) begin
            total_cnt++;
            $display("FAIL %s_timeout: got %0d results, required %0d", name, got_log.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        res_ready = 1'b0;
        repeat (2) tick();
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready); else pass_cnt++;
        total_cnt++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b required 0", res_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else pass_cnt++;
        total_cnt++; if ({mul_enable, mul_start} !== 2'b00) $display("FAIL reset_strobes: got %b required 00", {mul_enable, mul_start}); else pass_cnt++;
        total_cnt++; if (job_count !== 8'd0) $display("FAIL reset_job_count: got %0d required 0", job_count); else pass_cnt++;
        total_cnt++; if ({mul_a, mul_b, res_product} !== '0) $display("FAIL reset_data: got %h required 0", {mul_a, mul_b, res_product}); else pass_cnt++;
        rst = 1'b0;
        exp_jobs = 8'd0;
        res_ready = 1'b1;
        repeat (3) tick();
        total_cnt++; if (job_count !== 8'd0 || res_valid !== 1'b0) $display("FAIL idle_ready_ignored: job_count %0d res_valid %b required 0 0", job_count, res_valid); else pass_cnt++;
    endtask

    task automatic test_single();
        int e0 = enable_cyc;
        int s0 = start_cyc;
        int lat = -1;
        res_ready = 1'b1;
        in_a = 4'd7;
        in_b = 4'd8;
        in_valid = 1'b1;
        for (int i = 1; i <= 60 && lat < 0; i++) begin
            tick();
            if (i == 1) in_valid = 1'b0;
            if (res_valid) lat = i;
        end
        total_cnt++; if (lat != LATENCY + 4) $display("FAIL single_latency: got %0d cycles required %0d", lat, LATENCY + 4); else pass_cnt++;
        total_cnt++; if (res_product !== 8'd56) $display("FAIL single_product: got %0d required 56", res_product); else pass_cnt++;
        tick();
        exp_jobs = exp_jobs + 8'd1;
        total_cnt++; if (res_valid !== 1'b0) $display("FAIL single_handoff: res_valid %b required 0", res_valid); else pass_cnt++;
        total_cnt++; if (job_count !== exp_jobs) $display("FAIL single_job_count: got %0d required %0d", job_count, exp_jobs); else pass_cnt++;
        total_cnt++; if (enable_cyc - e0 != 1 || start_cyc - s0 != 1) $display("FAIL single_pulses: enable %0d start %0d required 1 1", enable_cyc - e0, start_cyc - s0); else pass_cnt++;
        total_cnt++; if (last_start_cyc != last_enable_cyc + 1) $display("FAIL single_order: start at %0d enable at %0d required start=enable+1", last_start_cyc, last_enable_cyc); else pass_cnt++;
    endtask

    task automatic test_queue_backpressure();
        int g0 = got_log.size();
        int want[3] = '{25, 143, 225};
        int w = 0;
        res_ready = 1'b0;
        push_pair(4'd5, 4'd5);
        push_pair(4'd13, 4'd11);
        push_pair(4'd15, 4'd15);
        total_cnt++; if (in_ready !== 1'b0 || busy !== 1'b1) $display("FAIL queue_full: in_ready %b busy %b required 0 1", in_ready, busy); else pass_cnt++;
        while (!res_valid && w < 100) begin
            tick();
            w++;
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            total_cnt++; if (res_valid !== 1'b1 || res_product !== 8'd25) $display("FAIL hold_stable: cycle %0d res_valid %b product %0d required 1 25", i, res_valid, res_product); else pass_cnt++;
        end
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL hold_in_ready: got %b required 0", in_ready); else pass_cnt++;
        res_ready = 1'b1;
        wait_results(g0 + 3, 200, "queue");
        for (int i = 0; i < 3; i++) begin
            if (got_log.size() > g0 + i) begin
                total_cnt++; if (got_log[g0 + i] != want[i] || exp_log[g0 + i] != want[i]) $display("FAIL queue_result%0d: got %0d model %0d required %0d", i, got_log[g0 + i], exp_log[g0 + i], want[i]); else pass_cnt++;
            end
        end
        exp_jobs = exp_jobs + 8'd3;
        total_cnt++; if (job_count !== exp_jobs) $display("FAIL queue_job_count: got %0d required %0d", job_count, exp_jobs); else pass_cnt++;
    endtask

    task automatic test_extremes();
        int g0 = got_log.size();
        int want[3] = '{0, 30, 225};
        res_ready = 1'b1;
        push_pair(4'd3, 4'd0);
        push_pair(4'd2, 4'd15);
        push_pair(4'd15, 4'd15);
        wait_results(g0 + 3, 200, "extremes");
        for (int i = 0; i < 3; i++) begin
            if (got_log.size() > g0 + i) begin
                total_cnt++; if (got_log[g0 + i] != want[i]) $display("FAIL extreme%0d: got %0d required %0d", i, got_log[g0 + i], want[i]); else pass_cnt++;
            end
        end
        exp_jobs = exp_jobs + 8'd3;
    endtask

    task automatic test_random();
        int g0 = got_log.size();
        int n = 24;
        int bad = 0;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    push_pair(WIDTH'($urandom), WIDTH'($urandom));
                end
            end
            begin
                repeat (300) begin
                    tick();
                    res_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        res_ready = 1'b1;
        wait_results(g0 + n, 400, "random");
        for (int i = g0; i < got_log.size(); i++) begin
            if (got_log[i] != exp_log[i]) begin
                if (bad == 0) $display("FAIL random_result%0d: got %0d required %0d", i - g0, got_log[i], exp_log[i]);
                bad++;
            end
        end
        total_cnt++; if (bad != 0 || got_log.size() != g0 + n) $display("FAIL random_scoreboard: %0d bad of %0d results, required 0 bad of %0d", bad, got_log.size() - g0, n); else pass_cnt++;
        exp_jobs = exp_jobs + 8'(n);
        total_cnt++; if (job_count !== exp_jobs) $display("FAIL random_job_count: got %0d required %0d", job_count, exp_jobs); else pass_cnt++;
    endtask

    task automatic test_reset_mid_wait();
        int w = 0;
        int e0, r0, g0;
        res_ready = 1'b1;
        push_pair(4'd10, 4'd10);
        while (!mul_start && w < 50) begin
            tick();
            w++;
        end
        repeat (2) tick();
        push_pair(4'd9, 4'd9);
        total_cnt++; if (busy !== 1'b1 || res_valid !== 1'b0) $display("FAIL midwait_precond: busy %b res_valid %b required 1 0", busy, res_valid); else pass_cnt++;
        e0 = enable_cyc;
        r0 = resv_cyc;
        g0 = got_log.size();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_jobs = 8'd0;
        total_cnt++; if (busy !== 1'b0 || res_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL midwait_reset: busy %b res_valid %b in_ready %b required 0 0 1", busy, res_valid, in_ready); else pass_cnt++;
        total_cnt++; if (job_count !== 8'd0) $display("FAIL midwait_job_count: got %0d required 0", job_count); else pass_cnt++;
        repeat (LATENCY + 8) tick();
        total_cnt++; if (enable_cyc != e0 || resv_cyc != r0 || got_log.size() != g0) $display("FAIL midwait_lost: enables %0d res_valid cycles %0d results %0d required 0 0 0", enable_cyc - e0, resv_cyc - r0, got_log.size() - g0); else pass_cnt++;
    endtask

    task automatic test_wrap();
        int g0;
        int bad = 0;
        int gap_bad = 0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        exp_jobs = 8'd0;
        res_ready = 1'b1;
        g0 = got_log.size();
        for (int i = 0; i < 256; i++) push_pair(WIDTH'($urandom), WIDTH'($urandom));
        wait_results(g0 + 256, 5000, "wrap");
        for (int i = g0; i < got_log.size(); i++) begin
            if (got_log[i] != exp_log[i]) bad++;
            if (i > g0 && got_cyc[i] - got_cyc[i - 1] != LATENCY + 4) gap_bad++;
        end
        total_cnt++; if (bad != 0 || got_log.size() != g0 + 256) $display("FAIL wrap_scoreboard: %0d bad of %0d results, required 0 bad of 256", bad, got_log.size() - g0); else pass_cnt++;
        total_cnt++; if (gap_bad != 0) $display("FAIL wrap_throughput: %0d gaps differ, required all %0d cycles", gap_bad, LATENCY + 4); else pass_cnt++;
        total_cnt++; if (job_count !== 8'd0) $display("FAIL wrap_job_count: got %0d required 0", job_count); else pass_cnt++;
    endtask

    task automatic test_invariants();
        total_cnt++; if (overlap_cnt != 0) $display("FAIL strobe_overlap: got %0d cycles required 0", overlap_cnt); else pass_cnt++;
        total_cnt++; if (stab_err != 0) $display("FAIL operand_stability: got %0d changes required 0", stab_err); else pass_cnt++;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_queue_backpressure();
        test_extremes();
        test_random();
        test_reset_mid_wait();
        test_wrap();
        test_invariants();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
